// File: rtl/hash_stream_arbiter.sv
// Packet-level round-robin arbiter feeding one padder/hash pipeline from NUM_PORTS
// AXI-Stream message sources; the grant is locked per message and the source index is stamped into TUSER.
module hash_stream_arbiter #(
    parameter int unsigned NUM_PORTS          = 4,
    parameter int unsigned C_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned SRC_ID_OFFSET      = 40,
    parameter int unsigned SRC_ID_WIDTH       = 4
) (
    input  logic                                      axis_aclk,
    input  logic                                      axis_reset,

    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [NUM_PORTS-1:0]                      s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                      m_axis_tvalid,
    output logic                                      m_axis_tlast,
    input  logic                                      m_axis_tready,

    output logic [NUM_PORTS-1:0]                      grant,
    output logic                                      busy
);

    localparam int unsigned KEEP_W = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [IDX_W-1:0]                g_idx;
    logic [IDX_W-1:0]                last_grant;
    logic [IDX_W-1:0]                pick_idx;
    logic                            pick_vld;
    logic                            out_free;
    logic                            accept;
    logic [NUM_PORTS-1:0]            ready;

    logic [C_AXIS_DATA_WIDTH-1:0]    data_arr [NUM_PORTS];
    logic [KEEP_W-1:0]               keep_arr [NUM_PORTS];
    logic [C_AXIS_TUSER_WIDTH-1:0]   user_arr [NUM_PORTS];

    logic [C_AXIS_DATA_WIDTH-1:0]    sel_data;
    logic [KEEP_W-1:0]               sel_keep;
    logic [C_AXIS_TUSER_WIDTH-1:0]   sel_user;
    logic                            sel_last;
    logic                            sel_valid;

    // Unpack the flat per-port buses so the locked port can be selected by index.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign data_arr[gi] = s_axis_tdata[gi*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        assign keep_arr[gi] = s_axis_tkeep[gi*KEEP_W +: KEEP_W];
        assign user_arr[gi] = s_axis_tuser[gi*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
    end

    // Round-robin pick: first valid port after last_grant, wrapping modulo NUM_PORTS.
    always_comb begin
        int unsigned cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
            cand = (32'(last_grant) + off) % NUM_PORTS;
            if (!pick_vld && s_axis_tvalid[IDX_W'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(cand);
            end
        end
    end

    // Output register can take a beat when empty or draining this cycle.
    assign out_free  = ~m_axis_tvalid | m_axis_tready;
    assign sel_data  = data_arr[g_idx];
    assign sel_keep  = keep_arr[g_idx];
    assign sel_last  = s_axis_tlast[g_idx];
    assign sel_valid = s_axis_tvalid[g_idx];
    assign accept    = (state == LOCK) & sel_valid & out_free;

    always_comb begin
        sel_user = user_arr[g_idx];
        sel_user[SRC_ID_OFFSET +: SRC_ID_WIDTH] = SRC_ID_WIDTH'(g_idx);
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-port ready; only the locked port ever sees ready.
    always_comb begin
        state_nxt = state;
        ready     = '0;
        case (state)
            ARB: begin
                if (pick_vld) begin
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                ready[g_idx] = out_free;
                if (accept && sel_last) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    assign s_axis_tready = ready;

    // Grant bookkeeping: lock on pick, release and advance the pointer on the tlast beat.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            grant      <= '0;
            g_idx      <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
        end else if (state == ARB) begin
            if (pick_vld) begin
                grant <= NUM_PORTS'(1) << pick_idx;
                g_idx <= pick_idx;
            end
        end else if (accept && sel_last) begin
            grant      <= '0;
            last_grant <= g_idx;
        end
    end

    // Single-stage output buffer in front of the padder.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= sel_last;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tuser  <= sel_user;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    assign busy = (state == LOCK) | m_axis_tvalid;

endmodule

// File: tb/tb_hash_stream_arbiter.sv
// Directed self-checking bench for hash_stream_arbiter with a per-port message source model.
module tb_hash_stream_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 512;
    localparam int unsigned UW = 128;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP*UW-1:0]  s_tuser;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [NP-1:0]     grant;
    logic              busy;

    logic [DW-1:0] in_data [NP];
    logic [KW-1:0] in_keep [NP];
    logic [UW-1:0] in_user [NP];

    always #5 clk = ~clk;

    for (genvar gp = 0; gp < NP; gp++) begin : g_pack
        assign s_tdata[gp*DW +: DW] = in_data[gp];
        assign s_tkeep[gp*KW +: KW] = in_keep[gp];
        assign s_tuser[gp*UW +: UW] = in_user[gp];
    end

    hash_stream_arbiter #(
        .NUM_PORTS(NP), .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW),
        .SRC_ID_OFFSET(40), .SRC_ID_WIDTH(4)
    ) dut (
        .axis_aclk(clk), .axis_reset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .grant(grant), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Source model state per port.
    int unsigned src_len  [NP];
    int unsigned src_beat [NP];
    int unsigned src_msg  [NP];
    int unsigned src_left [NP];
    logic [1:0]  src_sha  [NP];

    // Values sampled on the falling edge.
    logic [NP-1:0] smp_grant;
    logic [NP-1:0] smp_sready;
    logic          smp_mvalid;
    logic          smp_busy;
    logic [DW-1:0] smp_data;

    // Beats accepted by the padder side.
    logic [DW-1:0] cap_data [$];
    logic [KW-1:0] cap_keep [$];
    logic [UW-1:0] cap_user [$];
    logic          cap_last [$];

    function automatic logic [DW-1:0] mk_data(int unsigned p, int unsigned m, int unsigned b);
        logic [31:0] w;
        w = {8'hA5, 8'(p), 8'(m), 8'(b)};
        return {16{w}};
    endfunction

    function automatic logic [KW-1:0] mk_keep(int unsigned p, int unsigned b);
        return 64'hFFFF_FFFF_FFFF_FF00 | 64'(p * 16 + b);
    endfunction

    function automatic logic [UW-1:0] mk_user(int unsigned p, logic [1:0] sha, logic [3:0] id);
        return {64'hC0DE_0000_0000_0000 | 64'(p), 20'h0, id, 6'h0, sha, 32'h1234_5678};
    endfunction

    task automatic drive_inputs();
        for (int p = 0; p < NP; p++) begin
            s_tvalid[IW'(p)] = (src_left[p] != 0);
            s_tlast[IW'(p)]  = (src_beat[p] == src_len[p] - 1);
            in_data[p] = mk_data(p, src_msg[p], src_beat[p]);
            in_keep[p] = mk_keep(p, src_beat[p]);
            in_user[p] = mk_user(p, src_sha[p], 4'hF);
        end
    endtask

    task automatic start_src(int unsigned p, int unsigned len, int unsigned nmsg, logic [1:0] sha);
        src_len[p]  = len;
        src_beat[p] = 0;
        src_msg[p]  = 0;
        src_left[p] = nmsg;
        src_sha[p]  = sha;
        drive_inputs();
    endtask

    task automatic clear_srcs();
        for (int p = 0; p < NP; p++) begin
            src_len[p] = 1; src_beat[p] = 0; src_msg[p] = 0; src_left[p] = 0; src_sha[p] = 2'b00;
        end
        drive_inputs();
    endtask

    // One clock: sample on the falling edge, then advance the sources after the rising edge.
    task automatic tick();
        logic [NP-1:0] hs;
        @(negedge clk);
        smp_grant  = grant;
        smp_sready = s_tready;
        smp_mvalid = m_tvalid;
        smp_busy   = busy;
        smp_data   = m_tdata;
        hs = s_tvalid & s_tready;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            cap_data.push_back(m_tdata);
            cap_keep.push_back(m_tkeep);
            cap_user.push_back(m_tuser);
            cap_last.push_back(m_tlast);
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs[IW'(p)] === 1'b1) begin
                if (src_beat[p] == src_len[p] - 1) begin
                    src_beat[p] = 0;
                    src_msg[p]++;
                    src_left[p]--;
                end else begin
                    src_beat[p]++;
                end
            end
        end
        drive_inputs();
    endtask

    task automatic clear_caps();
        cap_data.delete(); cap_keep.delete(); cap_user.delete(); cap_last.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_tready = 1'b1;
        clear_srcs();
        tick();
        tick();
        rst = 1'b0;
        clear_caps();
    endtask

    // Runs until all sources are done and the arbiter is idle; ok=0 if the budget expires.
    task automatic wait_drain(int unsigned max_cyc, output bit ok);
        bit pending;
        ok = 1'b0;
        for (int unsigned i = 0; i < max_cyc && !ok; i++) begin
            tick();
            pending = 1'b0;
            for (int p = 0; p < NP; p++) if (src_left[p] != 0) pending = 1'b1;
            if (!pending && smp_busy === 1'b0 && smp_mvalid === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_tready = 1'b1;
        clear_srcs();
        start_src(0, 2, 1, 2'b01);
        tick();
        tick();
        checks++;
        if ({m_tvalid, m_tlast, grant, busy, s_tready} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b last=%b grant=%b busy=%b sready=%b, expected all 0",
                     m_tvalid, m_tlast, grant, busy, s_tready);
        end
        checks++;
        if ({m_tdata, m_tkeep, m_tuser} !== '0) begin
            errors++;
            $display("FAIL reset_data: got data=%h keep=%h user=%h, expected 0", m_tdata[31:0], m_tkeep, m_tuser);
        end
        rst = 1'b0;
        clear_srcs();
        clear_caps();
    endtask

    task automatic test_single();
        bit ok;
        logic [DW-1:0] ed;
        logic [KW-1:0] ek;
        logic [UW-1:0] eu;
        do_reset();
        start_src(2, 3, 1, 2'b10);
        tick();
        checks++;
        if (smp_grant !== 4'b0000 || smp_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_c0: got grant=%b mvalid=%b, expected 0000/0", smp_grant, smp_mvalid);
        end
        tick();
        checks++;
        if (smp_grant !== 4'b0100 || smp_sready !== 4'b0100 || smp_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_c1: got grant=%b sready=%b mvalid=%b, expected 0100/0100/0",
                     smp_grant, smp_sready, smp_mvalid);
        end
        tick();
        checks++;
        if (smp_mvalid !== 1'b1 || smp_grant !== 4'b0100) begin
            errors++;
            $display("FAIL single_c2: got mvalid=%b grant=%b, expected 1/0100", smp_mvalid, smp_grant);
        end
        wait_drain(50, ok);
        checks++;
        if (!ok || cap_data.size() != 3) begin
            errors++;
            $display("FAIL single_count: got %0d beats (drained=%0d), expected 3", cap_data.size(), ok);
        end
        for (int k = 0; k < 3 && k < cap_data.size(); k++) begin
            ed = mk_data(2, 0, k); ek = mk_keep(2, k); eu = mk_user(2, 2'b10, 4'd2);
            checks++;
            if (cap_data[k] !== ed || cap_keep[k] !== ek || cap_user[k] !== eu || cap_last[k] !== (k == 2)) begin
                errors++;
                $display("FAIL single_beat%0d: got data=%h user=%h last=%b, expected data=%h user=%h last=%b",
                         k, cap_data[k][31:0], cap_user[k], cap_last[k], ed[31:0], eu, (k == 2));
            end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int unsigned m, p;
        logic [DW-1:0] ed;
        logic [UW-1:0] eu;
        do_reset();
        for (int i = 0; i < NP; i++) start_src(i, 2, 2, 2'(i));
        wait_drain(300, ok);
        checks++;
        if (!ok || cap_data.size() != 16) begin
            errors++;
            $display("FAIL fair_count: got %0d beats (drained=%0d), expected 16", cap_data.size(), ok);
        end
        for (int k = 0; k < 16 && k < cap_data.size(); k++) begin
            m = k / 2;
            p = m % NP;
            ed = mk_data(p, m / NP, k % 2);
            eu = mk_user(p, 2'(p), 4'(p));
            checks++;
            if (cap_data[k] !== ed || cap_user[k] !== eu || cap_last[k] !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL fair_beat%0d: got data=%h user=%h last=%b, expected data=%h user=%h",
                         k, cap_data[k][31:0], cap_user[k], cap_last[k], ed[31:0], eu);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [DW-1:0] ed;
        do_reset();
        start_src(1, 6, 1, 2'b01);
        for (int i = 0; i < 20 && cap_data.size() < 2; i++) tick();
        m_tready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            ed = mk_data(1, 0, 2);
            checks++;
            if (smp_mvalid !== 1'b1 || smp_data !== ed || smp_sready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_stall%0d: got mvalid=%b data=%h sready=%b, expected 1/%h/0000",
                         s, smp_mvalid, smp_data[31:0], smp_sready, ed[31:0]);
            end
        end
        m_tready = 1'b1;
        wait_drain(50, ok);
        checks++;
        if (!ok || cap_data.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d beats (drained=%0d), expected 6", cap_data.size(), ok);
        end
        for (int k = 0; k < 6 && k < cap_data.size(); k++) begin
            ed = mk_data(1, 0, k);
            checks++;
            if (cap_data[k] !== ed || cap_last[k] !== (k == 5)) begin
                errors++;
                $display("FAIL bp_beat%0d: got data=%h last=%b, expected data=%h last=%b",
                         k, cap_data[k][31:0], cap_last[k], ed[31:0], (k == 5));
            end
        end
    endtask

    task automatic test_throughput();
        bit ok;
        int n;
        do_reset();
        start_src(3, 8, 1, 2'b11);
        for (int i = 0; i < 10 && smp_mvalid !== 1'b1; i++) tick();
        n = (smp_mvalid === 1'b1) ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (smp_mvalid === 1'b1) n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL tput_run: got %0d valid cycles, expected 8", n);
        end
        tick();
        checks++;
        if (smp_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL tput_end: got mvalid=%b after 8 beats, expected 0", smp_mvalid);
        end
        wait_drain(20, ok);
        checks++;
        if (!ok || cap_data.size() != 8 || cap_last[cap_last.size()-1] !== 1'b1) begin
            errors++;
            $display("FAIL tput_count: got %0d beats (drained=%0d), expected 8 ending in tlast", cap_data.size(), ok);
        end
    endtask

    task automatic test_wrap_skip();
        bit ok;
        logic [UW-1:0] eu;
        do_reset();
        start_src(3, 1, 1, 2'b00);
        wait_drain(20, ok);
        eu = mk_user(3, 2'b00, 4'd3);
        checks++;
        if (!ok || cap_data.size() != 1 || cap_last[0] !== 1'b1 || cap_user[0] !== eu) begin
            errors++;
            $display("FAIL wrap_single: got %0d beats (drained=%0d), expected one tlast beat user=%h",
                     cap_data.size(), ok, eu);
        end
        clear_caps();
        start_src(1, 1, 1, 2'b00);
        for (int i = 0; i < 10 && smp_grant === 4'b0000; i++) tick();
        checks++;
        if (smp_grant !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_grant: got grant=%b, expected 0010", smp_grant);
        end
        wait_drain(20, ok);
        checks++;
        if (!ok || cap_data.size() != 1 || cap_user[0][43:40] !== 4'd1) begin
            errors++;
            $display("FAIL wrap_msg: got %0d beats (drained=%0d), expected one beat from port 1", cap_data.size(), ok);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        start_src(0, 4, 1, 2'b00);
        for (int i = 0; i < 20 && src_beat[0] != 2; i++) tick();
        checks++;
        if (src_beat[0] != 2) begin
            errors++;
            $display("FAIL rmid_progress: got %0d beats accepted, expected 2", src_beat[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_srcs();
        clear_caps();
        tick();
        checks++;
        if (smp_mvalid !== 1'b0 || smp_grant !== 4'b0000 || smp_busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state: got mvalid=%b grant=%b busy=%b, expected 0/0000/0",
                     smp_mvalid, smp_grant, smp_busy);
        end
        start_src(2, 1, 1, 2'b00);
        start_src(0, 1, 1, 2'b00);
        tick();
        tick();
        checks++;
        if (smp_grant !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_grant: got grant=%b, expected 0001", smp_grant);
        end
        wait_drain(30, ok);
        checks++;
        if (!ok || cap_data.size() != 2 || cap_user[0][43:40] !== 4'd0 || cap_user[1][43:40] !== 4'd2) begin
            errors++;
            $display("FAIL rmid_order: got %0d beats (drained=%0d), expected port 0 then port 2", cap_data.size(), ok);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_tready = 1'b1;
        clear_srcs();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_throughput();
        test_wrap_skip();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
